// File: rtl/ysyx_23060240_gpr_sb_pkg.sv
// rtl/ysyx_23060240_gpr_sb_pkg.sv - shared state encoding and default widths for the GPR scoreboard
package ysyx_23060240_gpr_sb_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_RD     = 2;
  localparam int DEF_NUM_WR     = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/ysyx_23060240_gpr_sb_if.sv
// rtl/ysyx_23060240_gpr_sb_if.sv - issue/read/writeback bundle between core pipeline and register file
interface ysyx_23060240_gpr_sb_if
  import ysyx_23060240_gpr_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int NUM_WR     = DEF_NUM_WR
) ();

  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         iss_valid;
  logic [ADDR_WIDTH-1:0]        iss_rd;
  logic                         iss_ready;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         init_done;
  logic                         wb_err;

  modport master (
    output rd_addr, iss_valid, iss_rd, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, iss_ready, init_done, wb_err
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, iss_ready, init_done, wb_err
  );

endinterface

// File: rtl/ysyx_23060240_gpr_wb_sel.sv
// rtl/ysyx_23060240_gpr_wb_sel.sv - finds the highest-index writeback port targeting one address
module ysyx_23060240_gpr_wb_sel
  import ysyx_23060240_gpr_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WR     = DEF_NUM_WR
) (
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  output logic                         hit_o,
  output logic [DATA_WIDTH-1:0]        data_o
);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/ysyx_23060240_gpr_sb.sv
// rtl/ysyx_23060240_gpr_sb.sv - multi-port register file with busy scoreboard, bypass and init sequencer
module ysyx_23060240_gpr_sb
  import ysyx_23060240_gpr_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int NUM_WR     = DEF_NUM_WR,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060240_gpr_sb_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  gpr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic                  wb_err_q, wb_err_d;
  logic                  run;
  logic                  iss_hit;
  logic [DATA_WIDTH-1:0] iss_unused_data;
  logic                  rd_hit  [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_byp  [NUM_RD];

  assign run = (state_q == ST_RUN);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_sel
    ysyx_23060240_gpr_wb_sel #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WR(NUM_WR)
    ) u_sel (
      .addr_i   (bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_en_i  (bus.wr_en),
      .wr_addr_i(bus.wr_addr),
      .wr_data_i(bus.wr_data),
      .hit_o    (rd_hit[p]),
      .data_o   (rd_byp[p])
    );
  end

  ysyx_23060240_gpr_wb_sel #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WR(NUM_WR)
  ) u_iss_sel (
    .addr_i   (bus.iss_rd),
    .wr_en_i  (bus.wr_en),
    .wr_addr_i(bus.wr_addr),
    .wr_data_i(bus.wr_data),
    .hit_o    (iss_hit),
    .data_o   (iss_unused_data)
  );

  // x0 and the init phase both read as zero and never report pending.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (run && (bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = (BYPASS && rd_hit[p]) ? rd_byp[p]
                                                : mem_q[bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        bus.rd_busy[p] = busy_q[bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] & ~(BYPASS & rd_hit[p]);
      end
    end
  end

  assign bus.iss_ready = run & ((bus.iss_rd == '0) | ~busy_q[bus.iss_rd] | iss_hit);
  assign bus.init_done = run;
  assign bus.wb_err    = wb_err_q;

  // Clears come before the issue set so a same-cycle new producer keeps the bit.
  always_comb begin
    busy_d   = busy_q;
    wb_err_d = wb_err_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        if (!busy_q[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]]) wb_err_d = 1'b1;
        busy_d[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      idx_q    <= '0;
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          idx_q <= idx_q + ADDR_WIDTH'(1);
          if (idx_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= ST_RUN;
        end
        ST_RUN: begin
          busy_q   <= busy_d;
          wb_err_q <= wb_err_d;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_q[idx_q] <= '0;
      end else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0))
            mem_q[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_gpr_sb.sv
// tb/tb_ysyx_23060240_gpr_sb.sv - directed and randomized checks against a behavioural register-file model
module tb_ysyx_23060240_gpr_sb;
  import ysyx_23060240_gpr_sb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060240_gpr_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  ysyx_23060240_gpr_sb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_err;
  bit            m_run;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_addr   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
  endtask

  function automatic int wa(int w);
    return int'(bus.wr_addr[w*AW +: AW]);
  endfunction

  function automatic bit m_hit(int a);
    for (int w = 0; w < NW; w++)
      if (bus.wr_en[w] && wa(w) == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_read(int a);
    if (!m_run || a == 0) return '0;
    for (int w = NW - 1; w >= 0; w--)
      if (bus.wr_en[w] && wa(w) == a) return bus.wr_data[w*DW +: DW];
    return m_mem[a];
  endfunction

  function automatic bit m_ready();
    int a = int'(bus.iss_rd);
    return m_run && (a == 0 || !m_busy[a] || m_hit(a));
  endfunction

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NR; p++) begin
      int a = int'(bus.rd_addr[p*AW +: AW]);
      chk({tag, ".rd_data"}, 64'(bus.rd_data[p*DW +: DW]), 64'(m_read(a)));
      chk({tag, ".rd_busy"}, 64'(bus.rd_busy[p]), 64'(m_run && m_busy[a] && !m_hit(a)));
    end
    chk({tag, ".iss_ready"}, 64'(bus.iss_ready), 64'(m_ready()));
    chk({tag, ".init_done"}, 64'(bus.init_done), 64'(m_run));
    chk({tag, ".wb_err"}, 64'(bus.wb_err), 64'(m_err));
  endtask

  task automatic model_update();
    bit old_busy [DEPTH];
    bit acc;
    if (!m_run) return;
    old_busy = m_busy;
    acc = m_ready() && bus.iss_valid;
    for (int w = 0; w < NW; w++) begin
      if (bus.wr_en[w] && wa(w) != 0) begin
        if (!old_busy[wa(w)]) m_err = 1'b1;
        m_mem[wa(w)]  = bus.wr_data[w*DW +: DW];
        m_busy[wa(w)] = 1'b0;
      end
    end
    if (acc && bus.iss_rd != 0) m_busy[int'(bus.iss_rd)] = 1'b1;
  endtask

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    model_update();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // Holds rst for one edge, then walks the init phase with random noise on the inputs.
  task automatic reset_and_init(input string tag);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_run = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0;
      m_mem[i]  = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr   = {rnd_addr(), rnd_addr()};
      bus.iss_rd    = rnd_addr();
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.wr_en     = NW'($urandom_range(0, 3));
      bus.wr_addr   = {rnd_addr(), rnd_addr()};
      bus.wr_data   = {$urandom(), $urandom()};
      #1;
      check_outputs(tag);
      @(posedge clk);
      #1;
    end
    idle();
    m_run = 1'b1;
    #1;
    chk({tag, ".done_after_32"}, 64'(bus.init_done), 64'd1);
  endtask

  task automatic scan_zero(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      bus.rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      chk({tag, ".zero_lo"}, 64'(bus.rd_data[DW-1:0]), 64'd0);
      chk({tag, ".zero_hi"}, 64'(bus.rd_data[2*DW-1:DW]), 64'd0);
      step(tag);
    end
  endtask

  initial begin
    idle();
    reset_and_init("reset");
    scan_zero("scan0");

    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; step("iss5");
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; step("iss7");
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; step("iss3");

    bus.rd_addr = {5'd0, 5'd3}; bus.iss_rd = 5'd3;
    #1;
    chk("sb.busy3", 64'(bus.rd_busy[0]), 64'd1);
    chk("sb.stall3", 64'(bus.iss_ready), 64'd0);
    step("sb");

    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {32'h0, 32'hDEADBEEF};
    bus.rd_addr = {5'd0, 5'd5};
    #1;
    chk("wr5.bypass", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);
    step("wr5");
    bus.rd_addr = {5'd5, 5'd0};
    #1;
    chk("wr5.array", 64'(bus.rd_data[2*DW-1:DW]), 64'hDEADBEEF);
    step("rd5");

    bus.wr_en = 2'b11; bus.wr_addr = {5'd7, 5'd7}; bus.wr_data = {32'h22, 32'h11};
    bus.rd_addr = {5'd7, 5'd7};
    #1;
    chk("conf.bypass", 64'(bus.rd_data[DW-1:0]), 64'h22);
    step("conf");
    bus.rd_addr = {5'd0, 5'd7};
    #1;
    chk("conf.array", 64'(bus.rd_data[DW-1:0]), 64'h22);
    step("conf_rd");

    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd3}; bus.wr_data = {32'h0, 32'h33};
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; bus.rd_addr = {5'd0, 5'd3};
    #1;
    chk("wb3.ready", 64'(bus.iss_ready), 64'd1);
    chk("wb3.busy_byp", 64'(bus.rd_busy[0]), 64'd0);
    step("wb3");
    bus.rd_addr = {5'd0, 5'd3}; bus.iss_rd = 5'd3;
    #1;
    chk("wb3.newprod", 64'(bus.rd_busy[0]), 64'd1);
    step("wb3_after");

    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd0}; bus.wr_data = {32'h0, 32'h55};
    bus.rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0.read", 64'(bus.rd_data[DW-1:0]), 64'd0);
    chk("x0.ready", 64'(bus.iss_ready), 64'd1);
    step("x0");
    #1;
    chk("x0.no_err", 64'(bus.wb_err), 64'd0);
    chk("x0.not_busy", 64'(bus.rd_busy[0]), 64'd0);

    bus.wr_en = 2'b10; bus.wr_addr = {5'd9, 5'd0}; bus.wr_data = {32'h99, 32'h0};
    step("wb9");
    #1;
    chk("wb9.err", 64'(bus.wb_err), 64'd1);

    for (int n = 0; n < 400; n++) begin
      bus.rd_addr   = {rnd_addr(), rnd_addr()};
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = rnd_addr();
      bus.wr_en     = NW'($urandom_range(0, 3));
      bus.wr_addr   = {rnd_addr(), rnd_addr()};
      bus.wr_data   = {$urandom(), $urandom()};
      step("rand");
    end

    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk("midinit.not_done", 64'(bus.init_done), 64'd0);
    reset_and_init("midinit");
    scan_zero("scan1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
